// File: rtl/meio_subtrator_if.sv
// Operand/result bundle for meio_subtrator.
// master drives in_valid/A/B/Cin; slave returns S/Cout/out_valid (and V with MEIO_SUBTRATOR_OVF_EN).
interface meio_subtrator_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;
`ifdef MEIO_SUBTRATOR_OVF_EN
  logic             V;
`endif

  modport master (
    output in_valid, A, B, Cin,
`ifdef MEIO_SUBTRATOR_OVF_EN
    input  V,
`endif
    input  S, Cout, out_valid
  );

  modport slave (
    input  in_valid, A, B, Cin,
`ifdef MEIO_SUBTRATOR_OVF_EN
    output V,
`endif
    output S, Cout, out_valid
  );
endinterface

// File: rtl/meio_subtrator.sv
// Registered WIDTH-bit subtractor with borrow-in/out, one-cycle latency.
// Ports: clk, rst_n (sync, active-low), io (slave). Optional V via MEIO_SUBTRATOR_OVF_EN.
module meio_subtrator #(
  parameter int WIDTH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  meio_subtrator_if.slave io
);
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             vld_q, vld_d;
  logic [WIDTH:0]   diff;

  // One extra bit captures the borrow: the MSB is set when A < B + Cin.
  assign diff = {1'b0, io.A} - {1'b0, io.B}
              - {{WIDTH{1'b0}}, io.Cin};

`ifdef MEIO_SUBTRATOR_OVF_EN
  logic v_q, v_d;
`endif

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    vld_d  = 1'b0;
`ifdef MEIO_SUBTRATOR_OVF_EN
    v_d    = v_q;
`endif
    if (io.in_valid) begin
      s_d    = diff[WIDTH-1:0];
      cout_d = diff[WIDTH];
      vld_d  = 1'b1;
`ifdef MEIO_SUBTRATOR_OVF_EN
      // Signed overflow: operand signs differ and result sign left A's.
      v_d = (io.A[WIDTH-1] != io.B[WIDTH-1]) &&
            (diff[WIDTH-1] != io.A[WIDTH-1]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
`ifdef MEIO_SUBTRATOR_OVF_EN
      v_q    <= 1'b0;
`endif
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
`ifdef MEIO_SUBTRATOR_OVF_EN
      v_q    <= v_d;
`endif
    end
  end

  assign io.S         = s_q;
  assign io.Cout      = cout_q;
  assign io.out_valid = vld_q;
`ifdef MEIO_SUBTRATOR_OVF_EN
  assign io.V         = v_q;
`endif
endmodule

// File: tb/tb_meio_subtrator.sv
// Directed bench for meio_subtrator at WIDTH=1 and WIDTH=8.
// Two DUT instances share clk/rst_n; checks sampled #1 after posedge.
module tb_meio_subtrator;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  meio_subtrator_if #(.WIDTH(1)) if1 ();
  meio_subtrator_if #(.WIDTH(8)) if8 ();

  meio_subtrator #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if1.slave)
  );

  meio_subtrator #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic c);
    if8.in_valid = v;
    if8.A        = a;
    if8.B        = b;
    if8.Cin      = c;
  endtask

  logic [2:0] vec1;
  logic [1:0] exp1 [8];
  logic [7:0] ra [16];
  logic [7:0] rb [16];
  logic       rc [16];
  int         ediff;

  initial begin
    errors = 0;
    checks = 0;
    // Expected (S,Cout) for A,B,Cin = 000..111
    exp1[0] = 2'b00; exp1[1] = 2'b11;
    exp1[2] = 2'b11; exp1[3] = 2'b01;
    exp1[4] = 2'b10; exp1[5] = 2'b00;
    exp1[6] = 2'b00; exp1[7] = 2'b11;

    // Reset with a valid operand present: must be discarded
    rst_n = 1'b0;
    if1.in_valid = 1'b1;
    if1.A = 1'b1; if1.B = 1'b0; if1.Cin = 1'b0;
    drive8(1'b1, 8'h01, 8'h00, 1'b0);
    tick();
    check("rst_s8", 32'(if8.S), 32'h0);
    check("rst_c8", 32'(if8.Cout), 32'h0);
    check("rst_v8", 32'(if8.out_valid), 32'h0);
    check("rst_s1", 32'(if1.S), 32'h0);
    check("rst_ov1", 32'(if1.out_valid), 32'h0);
`ifdef MEIO_SUBTRATOR_OVF_EN
    check("rst_ovf8", 32'(if8.V), 32'h0);
`endif
    tick();
    check("rst_hold_v8", 32'(if8.out_valid), 32'h0);

    // First valid after reset release
    rst_n = 1'b1;
    tick();
    check("post_rst_s8", 32'(if8.S), 32'h01);
    check("post_rst_c8", 32'(if8.Cout), 32'h0);
    check("post_rst_v8", 32'(if8.out_valid), 32'h1);

    // WIDTH=1 exhaustive, back to back
    for (int i = 0; i < 8; i++) begin
      vec1 = 3'(i);
      if1.A   = vec1[2];
      if1.B   = vec1[1];
      if1.Cin = vec1[0];
      if1.in_valid = 1'b1;
      tick();
      check($sformatf("w1_s_%0d", i), 32'(if1.S), 32'(exp1[i][1]));
      check($sformatf("w1_c_%0d", i), 32'(if1.Cout), 32'(exp1[i][0]));
      check($sformatf("w1_v_%0d", i), 32'(if1.out_valid), 32'h1);
    end
    if1.in_valid = 1'b0;

    // WIDTH=8 directed vectors
    drive8(1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    check("wrap_s", 32'(if8.S), 32'hFF);
    check("wrap_c", 32'(if8.Cout), 32'h1);
    drive8(1'b1, 8'h50, 8'h20, 1'b0);
    tick();
    check("sub_s", 32'(if8.S), 32'h30);
    check("sub_c", 32'(if8.Cout), 32'h0);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    tick();
    check("ones_c1_s", 32'(if8.S), 32'hFF);
    check("ones_c1_c", 32'(if8.Cout), 32'h1);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b0);
    tick();
    check("ones_c0_s", 32'(if8.S), 32'h00);
    check("ones_c0_c", 32'(if8.Cout), 32'h0);

    // Overflow flag
    drive8(1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    check("ovf_s", 32'(if8.S), 32'h7F);
    check("ovf_c", 32'(if8.Cout), 32'h0);
`ifdef MEIO_SUBTRATOR_OVF_EN
    check("ovf_v1", 32'(if8.V), 32'h1);
`endif
    drive8(1'b1, 8'h10, 8'h01, 1'b0);
    tick();
    check("novf_s", 32'(if8.S), 32'h0F);
`ifdef MEIO_SUBTRATOR_OVF_EN
    check("ovf_v0", 32'(if8.V), 32'h0);
`endif

    // Hold: one valid then three idle cycles
    drive8(1'b1, 8'h05, 8'h03, 1'b0);
    tick();
    check("hold_s0", 32'(if8.S), 32'h02);
    check("hold_v0", 32'(if8.out_valid), 32'h1);
    drive8(1'b0, 8'hAA, 8'hBB, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("hold_s%0d", i), 32'(if8.S), 32'h02);
      check($sformatf("hold_c%0d", i), 32'(if8.Cout), 32'h0);
      check($sformatf("hold_v%0d", i), 32'(if8.out_valid), 32'h0);
    end

    // Throughput: 16 random back-to-back operands
    for (int i = 0; i < 16; i++) begin
      ra[i] = 8'($urandom_range(0, 255));
      rb[i] = 8'($urandom_range(0, 255));
      rc[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 16; i++) begin
      drive8(1'b1, ra[i], rb[i], rc[i]);
      tick();
      ediff = int'(ra[i]) - int'(rb[i]) - int'(rc[i]);
      check($sformatf("rnd_s%0d", i), 32'(if8.S), 32'(ediff & 255));
      check($sformatf("rnd_c%0d", i), 32'(if8.Cout),
            (int'(ra[i]) < int'(rb[i]) + int'(rc[i])) ? 32'h1 : 32'h0);
      check($sformatf("rnd_v%0d", i), 32'(if8.out_valid), 32'h1);
    end
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check("rnd_end_v", 32'(if8.out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/meio_subtrator.md
MEIO_SUBTRATOR -- requirements
Module: meio_subtrator

Interface
REQ-001 Parameter WIDTH, default 1, operand/difference width in bits (legal range 1..32).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operands valid this cycle.
REQ-005 A  input  WIDTH  minuend, unsigned.
REQ-006 B  input  WIDTH  subtrahend, unsigned.
REQ-007 Cin  input  1  borrow-in.
REQ-008 S  output  WIDTH  registered difference.
REQ-009 Cout  output  1  registered borrow-out.
REQ-010 out_valid  output  1  S/Cout updated from a valid input on the previous edge.
REQ-011 V  output  1  registered signed-overflow flag; present only when MEIO_SUBTRATOR_OVF_EN is defined.

Function
REQ-012 Arithmetic SHALL be computed at WIDTH+1 bits: {Cout,S} = {1'b0,A} - {1'b0,B} - Cin, modulo 2^(WIDTH+1).
REQ-013 Cout SHALL be 1 exactly when A < B + Cin (unsigned, evaluated without truncation); otherwise 0.
REQ-014 For WIDTH=1, the result SHALL equal S = A^B^Cin and Cout = (~A&B) | (~(A^B)&Cin).
REQ-015 Latency SHALL be one clock: operands sampled on edge N with in_valid=1 appear on S/Cout after edge N, with out_valid=1.
REQ-016 On an edge with in_valid=0, S, Cout and V SHALL hold their previous values and out_valid SHALL be 0.
REQ-017 Back-to-back valid inputs SHALL be accepted every cycle with no stall; there is no backpressure.
REQ-018 Wrap-around: A=0, B=0, Cin=1 SHALL give S=all ones and Cout=1.
REQ-019 Boundary: A=all ones, B=all ones, Cin=1 SHALL give S=all ones and Cout=1; with Cin=0 it SHALL give S=0 and Cout=0.
REQ-020 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-021 When rst_n=0 at a rising edge, S, Cout, out_valid and V (if present) SHALL become 0, regardless of in_valid.
REQ-022 Reset SHALL take priority over a simultaneous valid input; operands presented in the reset cycle SHALL be discarded.
REQ-023 The first valid input after rst_n returns to 1 SHALL be processed normally with one-cycle latency.
REQ-024 Outputs before the first clock edge are not defined.

Configuration
REQ-025 Macro MEIO_SUBTRATOR_OVF_EN defined: port V SHALL exist and SHALL be registered with S.
REQ-026 V SHALL be 1 when the signed (two's complement) difference A - B - Cin is not representable in WIDTH bits, i.e. A[MSB] != B[MSB] and S[MSB] != A[MSB].
REQ-027 Macro not defined: port V and all of its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-028 WIDTH=1: apply all 8 combinations (A,B,Cin) in order 000..111, with in_valid=1 -> (S,Cout) = 00,11,11,01,10,00,00,11, each one cycle later.
REQ-029 WIDTH=8: A=0x00, B=0x00, Cin=1 -> S=0xFF, Cout=1; A=0x50, B=0x20, Cin=0 -> S=0x30, Cout=0.
REQ-030 Hold: one valid input (A=5, B=3, Cin=0, WIDTH=8), then in_valid=0 for 3 cycles -> S stays 0x02, Cout=0, out_valid=1 for one cycle only.
REQ-031 Reset: rst_n=0 together with in_valid=1 and A=1, B=0 -> S=0, Cout=0, out_valid=0 after the edge; the next valid input gives the correct result.
REQ-032 Overflow (OVF_EN, WIDTH=8): A=0x80, B=0x01, Cin=0 -> S=0x7F, V=1; A=0x10, B=0x01 -> V=0.
REQ-033 Throughput: 16 consecutive random valid inputs -> 16 consecutive correct results with out_valid held at 1.
